// File: rtl/noc_split.sv
// Ejection-side splitter: steers NoC packets to the core or bcont FIFO, drops on overflow.
// Optional drop counter port drop_cnt_o is compiled in with NOC_SPLIT_DROP_CNT_EN.
module noc_split #(
  parameter int DATA_WIDTH       = 65,
  parameter int VALID_BIT_OFFSET = 64,
  parameter int DEST_BIT_OFFSET  = 63,
  parameter int LEN_OFFSET       = 56,
  parameter int LEN_WIDTH        = 4,
  parameter int BUF_DEPTH        = 8,
  parameter int LOG2_BUF_DEPTH   = 3,
  parameter int STALL_MARGIN     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] noc_i,
  output logic [DATA_WIDTH-1:0] core_o,
  input  logic                  core_rdy_i,
  output logic [DATA_WIDTH-1:0] bcont_o,
  input  logic                  bcont_rdy_i,
  output logic                  noc_stall_o,
  output logic                  ovf_o
`ifdef NOC_SPLIT_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt_o
`endif
);

  localparam int OCC_W = LOG2_BUF_DEPTH + 1;
  localparam int PTR_W = LOG2_BUF_DEPTH;
  localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(BUF_DEPTH);
  localparam logic [OCC_W-1:0] STALL_OCC = OCC_W'(BUF_DEPTH - STALL_MARGIN);

  typedef enum logic {IDLE, BODY} state_t;

  state_t               state_q, state_n;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_n;
  logic                 cur_dest_q, cur_dest_n;
  logic                 flit_valid;
  logic                 route_bcont;

  // Index 0 is the core FIFO, index 1 the bcont FIFO.
  logic [DATA_WIDTH-1:0] mem [2][BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr [2];
  logic [PTR_W-1:0]      rd_ptr [2];
  logic [OCC_W-1:0]      occ [2];
  logic [1:0]            rdy, push, pop, accept, drop;

  assign flit_valid = noc_i[VALID_BIT_OFFSET];
  assign rdy        = {bcont_rdy_i, core_rdy_i};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_dest_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      cur_dest_q <= cur_dest_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    cur_dest_n = cur_dest_q;
    if (flit_valid) begin
      case (state_q)
        IDLE: begin
          cur_dest_n = noc_i[DEST_BIT_OFFSET];
          if (noc_i[LEN_OFFSET +: LEN_WIDTH] != '0) begin
            cnt_n   = noc_i[LEN_OFFSET +: LEN_WIDTH];
            state_n = BODY;
          end
        end
        BODY: begin
          if (cnt_q == LEN_WIDTH'(1)) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt_q - LEN_WIDTH'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Headers route by their own DEST bit; body flits follow the latched destination.
  always_comb begin
    route_bcont = (state_q == IDLE) ? noc_i[DEST_BIT_OFFSET] : cur_dest_q;
    push        = flit_valid ? (route_bcont ? 2'b10 : 2'b01) : 2'b00;
  end

  // Pop is resolved first so a full FIFO being drained can still take a push.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      pop[d]    = (occ[d] != '0) & rdy[d];
      accept[d] = push[d] & ((occ[d] != FULL_OCC) | pop[d]);
      drop[d]   = push[d] & ~accept[d];
    end
  end

  always_ff @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (accept[d]) mem[d][wr_ptr[d]] <= noc_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        wr_ptr[d] <= '0;
        rd_ptr[d] <= '0;
        occ[d]    <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (accept[d]) wr_ptr[d] <= wr_ptr[d] + PTR_W'(1);
        if (pop[d])    rd_ptr[d] <= rd_ptr[d] + PTR_W'(1);
        if (accept[d] && !pop[d])      occ[d] <= occ[d] + OCC_W'(1);
        else if (!accept[d] && pop[d]) occ[d] <= occ[d] - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       ovf_o <= 1'b0;
    else if (|drop) ovf_o <= 1'b1;
  end

`ifdef NOC_SPLIT_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              drop_cnt_o <= 8'd0;
    else if (|drop && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
  end
`endif

  always_comb begin
    core_o                    = mem[0][rd_ptr[0]];
    core_o[VALID_BIT_OFFSET]  = (occ[0] != '0);
    bcont_o                   = mem[1][rd_ptr[1]];
    bcont_o[VALID_BIT_OFFSET] = (occ[1] != '0);
    noc_stall_o               = (occ[0] >= STALL_OCC) | (occ[1] >= STALL_OCC);
  end

endmodule

// File: doc/noc_split.md
# noc_split

Ejection-side splitter between the NoC and a compute tile: takes the single NoC flit stream and steers each packet either to the core or to the block controller (bcont). It is the receive-direction counterpart of the arbiter that merges core and bcont traffic onto the NoC. Per-destination FIFOs absorb consumer stalls. An almost-full stall hint goes back toward the NoC, and any flit that overflows is dropped and flagged.

## Interface
- DATA_WIDTH, 65, flit width including valid bit
- VALID_BIT_OFFSET, 64, bit index of flit valid
- DEST_BIT_OFFSET, 63, header bit: 1 = bcont, 0 = core
- LEN_OFFSET, 56, LSB of header body-length field
- LEN_WIDTH, 4, body-length field width
- BUF_DEPTH, 8, entries per destination FIFO
- LOG2_BUF_DEPTH, 3, log2(BUF_DEPTH)
- STALL_MARGIN, 2, free-entry threshold for the stall hint
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous active-low reset (asserted when 0)
- noc_i  in  DATA_WIDTH  incoming flit; valid when bit VALID_BIT_OFFSET = 1
- core_o  out  DATA_WIDTH  core FIFO head; valid bit forced 0 when empty
- core_rdy_i  in  1  core consumes core_o this cycle
- bcont_o  out  DATA_WIDTH  bcont FIFO head; valid bit forced 0 when empty
- bcont_rdy_i  in  1  bcont consumes bcont_o this cycle
- noc_stall_o  out  1  either FIFO has ≤ STALL_MARGIN free entries
- ovf_o  out  1  sticky: at least one flit dropped since reset

## Operation
- Packets:
  - A header flit carries the destination (DEST bit) and body length L (LEN field, 0..2^LEN_WIDTH−1).
  - L body flits follow; each goes to the header's destination.
  - Flits with valid = 0 are bubbles: ignored, not counted, and allowed anywhere.
- FSM states:
  - IDLE: the next valid flit is a header.
    - Route it by its DEST bit and latch that destination into cur_dest.
    - If L = 0, stay in IDLE; otherwise load cnt = L and go to BODY.
  - BODY: each valid flit routes to cur_dest and decrements cnt.
    - When cnt reaches 1 and a valid flit arrives, go to IDLE.
  - Any valid flit received in BODY is a body flit, including one with header-like content.
- FIFO push: a routed valid flit is written, unmodified, into the destination FIFO.
- FIFO full:
  - If the destination FIFO is full and is not popped in the same cycle, the flit is dropped and ovf_o is set.
  - A dropped flit still advances the FSM and cnt, so packet framing is preserved.
- FIFO pop: the FIFO pops when its head is valid and the matching rdy_i is 1. rdy_i while empty is ignored.
- Simultaneous push and pop on one FIFO:
  - Both occur and occupancy is unchanged.
  - When full, the push is accepted because it is evaluated after the pop.
- The two FIFOs are fully independent; a stalled core never blocks bcont delivery.
- Occupancy counters are LOG2_BUF_DEPTH+1 bits wide. Read and write pointers wrap modulo BUF_DEPTH.
- noc_stall_o = (BUF_DEPTH − occ_core ≤ STALL_MARGIN) OR (BUF_DEPTH − occ_bcont ≤ STALL_MARGIN).
  - It is combinational from the registered occupancies.
  - It is advisory only: the block never back-pressures noc_i.

## Timing
- Reset values:
  - FSM = IDLE, cnt = 0, both FIFOs empty.
  - core_o and bcont_o have valid bit 0.
  - noc_stall_o = 0, ovf_o = 0.
  - drop counter = 0 when compiled in.
- Latency: a flit present on noc_i at edge N appears on its output after edge N (one cycle) when that FIFO was empty. There is no combinational path from noc_i to the outputs.
- Output data and valid come from FIFO head registers, stable for the whole cycle. Consumption happens at the edge where valid & rdy = 1, and the next entry is presented the following cycle.
- Throughput: one flit per cycle in and one per cycle per output.
- Reset asserted mid-packet: immediately returns to IDLE and empties both FIFOs. Residual body flits arriving after reset are interpreted as headers; upstream is responsible for flushing.
- ovf_o clears only on reset.

## Configuration
- NOC_SPLIT_DROP_CNT_EN
  - Defined: adds output port drop_cnt_o [7:0], an 8-bit count of dropped flits that saturates at 255 and resets to 0.
  - Undefined: the port and counter are absent; ovf_o still operates.

## Test plan
- Header to core with L=0, core_rdy_i=1 → core_o valid one cycle later with identical data; bcont_o valid stays 0; FSM stays IDLE.
- Header to bcont with L=3, then 3 body flits with 2 bubbles interleaved → all 4 flits appear on bcont_o in order; the next valid flit is parsed as a header.
- core_rdy_i=0; 8 core flits, then a 9th → first 8 buffered; noc_stall_o rises once occupancy ≥ 6; 9th dropped; ovf_o=1; drop_cnt_o=1 if enabled.
- Core FIFO full, core_rdy_i=1 while a new core flit arrives → pop and push both occur, occupancy stays 8, ovf_o stays 0.
- Core stalled, bcont packet L=2 arrives → bcont_o delivers 3 flits while core_o holds its head unchanged.
- rst pulsed low during BODY with cnt=2 → outputs invalid, noc_stall_o=0, ovf_o=0; next valid flit treated as header.
